// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with saturating match counter
// Pattern length, bits and overlap mode are reloadable at run time through cfg_we.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h0B),
  parameter int                 DEF_LEN     = 4,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  state_t             state, state_next;
  logic [MAX_LEN-1:0] history, hist_next, pattern, mask;
  logic [LEN_W-1:0]   fill, fill_next, len;
  logic               overlap;
  logic               take, cfg_ok, hit;

  // A configuration write always wins over a bit in the same cycle.
  assign take      = bit_valid && !cfg_we;
  assign cfg_ok    = cfg_we && (cfg_len >= LEN_W'(2)) && (cfg_len <= FILL_MAX);
  assign hist_next = (history << 1) | MAX_LEN'(bit_in);
  assign fill_next = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
  end

  assign hit = take && (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);

  always_comb begin
    state_next = state;
    if (cfg_ok) begin
      state_next = FILL;
    end else if (take) begin
      if (hit && !overlap)     state_next = FILL;
      else if (fill_next >= len) state_next = ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  assign armed = (state == ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history     <= '0;
      fill        <= '0;
      pattern     <= DEF_PATTERN;
      len         <= LEN_W'(DEF_LEN);
      overlap     <= 1'b1;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        history <= '0;
        fill    <= '0;
      end else if (take) begin
        history <= hist_next;
        fill    <= (hit && !overlap) ? '0 : fill_next;
      end
      // Clear beats a coincident increment; the match pulse itself is unaffected.
      if (clr) begin
        match_count <= '0;
        overflow    <= 1'b0;
      end else if (hit) begin
        if (match_count == CNT_MAX) overflow    <= 1'b1;
        else                        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - randomized bench for seq_detect_prog against a queue-based model
// Directed scenarios pin the model with literal values, then random traffic runs under it.
module tb_seq_detect_prog;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_in = 1'b0, bit_valid = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0, clr = 1'b0;
  logic [7:0]       cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic             match, overflow, armed, cfg_err;
  logic [CNT_W-1:0] match_count;

  int total = 0;
  int bad   = 0;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(CNT_W), .DEF_PATTERN(8'h0B), .DEF_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr(clr), .match(match), .match_count(match_count), .overflow(overflow),
    .armed(armed), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Model: a queue of the bits seen since the last config/reset/non-overlap match.
  bit       hq[$];
  bit [7:0] m_pat = 8'h0B;
  int       m_len = 4;
  bit       m_ovl = 1'b1;
  bit       e_match = 0, e_err = 0, e_ovf = 0, e_armed = 0;
  int       e_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    bit hit;
    if (!rst_n) begin
      hq.delete();
      m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
      e_match = 0; e_err = 0; e_cnt = 0; e_ovf = 0; e_armed = 0;
    end else begin
      hit = 0;
      e_err = 0;
      if (cfg_we) begin
        if (cfg_len >= 2 && cfg_len <= 8) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          hq.delete();
        end else begin
          e_err = 1;
        end
      end else if (bit_valid) begin
        hq.push_back(bit_in);
        if (hq.size() > 8) void'(hq.pop_front());
        if (hq.size() >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++)
            if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 0;
        end
        if (hit && !m_ovl) hq.delete();
      end
      e_match = hit;
      if (clr) begin
        e_cnt = 0; e_ovf = 0;
      end else if (hit) begin
        if (e_cnt == CMAX) e_ovf = 1;
        else               e_cnt = e_cnt + 1;
      end
      e_armed = (hq.size() >= m_len);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("match",       int'(match),       int'(e_match));
    check("match_count", int'(match_count), e_cnt);
    check("overflow",    int'(overflow),    int'(e_ovf));
    check("armed",       int'(armed),       int'(e_armed));
    check("cfg_err",     int'(cfg_err),     int'(e_err));
  end

  task automatic put_bit(input logic b, input logic v, input logic c);
    @(negedge clk); #1;
    bit_in = b; bit_valid = v; clr = c; cfg_we = 1'b0;
  endtask

  task automatic idle();
    put_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic v);
    @(negedge clk); #1;
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    bit_valid = v; bit_in = 1'b1; clr = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put_bit(s[i] == "1", 1'b1, 1'b0);
  endtask

  initial begin
    int r;
    repeat (2) @(negedge clk);
    check("reset_armed", int'(armed), 0);
    check("reset_count", int'(match_count), 0);
    #1 rst_n = 1'b1;

    send("1011"); idle();
    check("dflt_match", int'(match), 1);
    check("dflt_count", int'(match_count), 1);
    check("dflt_armed", int'(armed), 1);
    check("model_dflt_count", e_cnt, 1);

    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0); put_bit(1'b0, 1'b0, 1'b1);
    send("1011011"); idle();
    check("overlap_count", int'(match_count), 2);
    check("model_overlap_count", e_cnt, 2);

    do_cfg(8'h0B, 4'd4, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b1);
    send("1011011"); idle();
    check("nonoverlap_count", int'(match_count), 1);

    do_cfg(8'h33, 4'd6, 1'b1, 1'b0); put_bit(1'b0, 1'b0, 1'b1);
    check("recfg_armed", int'(armed), 0);
    send("01"); put_bit(1'b1, 1'b0, 1'b0); send("100");
    put_bit(1'b0, 1'b0, 1'b0); put_bit(1'b1, 1'b0, 1'b0);
    send("11"); idle();
    check("recfg_count", int'(match_count), 1);
    check("recfg_match", int'(match), 1);

    do_cfg(8'h00, 4'd1, 1'b0, 1'b1); idle();
    check("illegal_err", int'(cfg_err), 1);
    put_bit(1'b0, 1'b0, 1'b1);
    check("illegal_err_gone", int'(cfg_err), 0);
    send("110011"); idle();
    check("illegal_keeps_cfg", int'(match_count), 1);

    do_cfg(8'h33, 4'd6, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b1);
    repeat (5) send("110011");
    idle();
    check("sat_count", int'(match_count), 3);
    check("sat_overflow", int'(overflow), 1);
    send("11001"); put_bit(1'b1, 1'b1, 1'b1); idle();
    check("clr_match", int'(match), 1);
    check("clr_count", int'(match_count), 0);
    check("clr_overflow", int'(overflow), 0);

    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0);
    send("101");
    @(negedge clk); #1;
    rst_n = 1'b0; bit_valid = 1'b0;
    @(negedge clk); #1;
    check("midrst_armed", int'(armed), 0);
    rst_n = 1'b1;
    send("1"); idle();
    check("midrst_nomatch", int'(match), 0);
    send("011"); idle();
    check("midrst_fresh_match", int'(match_count), 1);

    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      @(negedge clk); #1;
      clr = ($urandom_range(0, 29) == 0);
      cfg_we = (r < 3);
      cfg_pattern = 8'($urandom);
      cfg_len = 4'($urandom_range(0, 10));
      cfg_overlap = 1'($urandom);
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in = 1'($urandom);
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL provide parameter DEF_PATTERN, default 8'h0B: pattern loaded at reset, right-aligned, width MAX_LEN.
REQ-004 SHALL provide parameter DEF_LEN, default 4: pattern length loaded at reset; the defaults detect "1011".
REQ-005 SHALL define LEN_W = clog2(MAX_LEN+1).
REQ-006 SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is accepted this cycle.
- cfg_we  in  1  load configuration this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
- cfg_len  in  LEN_W  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- clr  in  1  clear match_count and overflow.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  saturating count of matches.
- overflow  out  1  sticky; a match occurred while match_count was at maximum.
- armed  out  1  history holds at least len bits.
- cfg_err  out  1  one-cycle pulse when a cfg_we write is rejected.

Function
REQ-007 SHALL keep a MAX_LEN-bit history register; each accepted bit shifts in at bit 0, so bit 0 is the newest bit.
REQ-008 SHALL keep a fill counter fill (0..MAX_LEN) that increments on each accepted bit and saturates at MAX_LEN.
REQ-009 SHALL ignore bit_in and hold history and fill on any cycle where bit_valid=0.
REQ-010 SHALL match on an accepted bit when both hold:
- fill_next >= len.
- The low len bits of the next history equal the low len bits of pattern.
REQ-011 SHALL store the pattern with pattern[len-1] as the first bit received and pattern[0] as the last.
REQ-012 SHALL register match, so it asserts exactly one cycle after the clock edge that accepted the completing bit; latency is 1 cycle, identical to the previous fixed detector.
REQ-013 SHALL deassert match on every cycle without a qualifying accepted bit.
REQ-014 SHALL operate as a two-state FSM:
- FILL (fill < len) to ARMED when fill reaches len.
- ARMED to FILL on cfg_we acceptance, or on a match when overlap=0.
- armed = 1 in ARMED.
REQ-015 SHALL, in overlap mode, retain history and fill after a match; "1011011" with pattern "1011" yields 2 matches.
REQ-016 SHALL, in non-overlap mode, set fill to 0 after a match; the same stream yields 1 match.
REQ-017 SHALL accept cfg_we only if 2 <= cfg_len <= MAX_LEN, and on acceptance:
- Load pattern, len and overlap.
- Clear history and fill; the FSM enters FILL.
- Leave match_count and overflow unchanged.
REQ-018 SHALL, for an illegal cfg_len, leave all state unchanged and pulse cfg_err one cycle after the write.
REQ-019 SHALL give cfg_we priority over bit_valid in the same cycle; the bit is discarded, whether the write is accepted or rejected.
REQ-020 SHALL increment match_count on each match and saturate at 2^CNT_W-1.
REQ-021 SHALL set overflow when a match occurs while match_count is at its maximum; overflow stays set until clr or reset.
REQ-022 SHALL, on clr, set match_count=0 and overflow=0 on the next edge; clr has priority over a simultaneous match increment, but the match pulse itself is still emitted.
REQ-023 SHALL leave clr with no effect on history, fill, the FSM or the configuration.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force:
- history = 0, fill = 0, FSM = FILL.
- match = 0, match_count = 0, overflow = 0, armed = 0, cfg_err = 0.
- pattern = DEF_PATTERN, len = DEF_LEN, overlap = 1.
REQ-025 SHALL, if reset asserts mid-stream, discard all partial history; after release, a match requires len fresh accepted bits.
REQ-026 SHALL let the first accepted bit be sampled at the first rising clk edge after rst_n deasserts.

Verification
REQ-027 SHALL cover default config: after reset, drive bits 1,0,1,1 with bit_valid=1 -> match=1 exactly one cycle after the 4th bit, match_count=1, armed=1.
REQ-028 SHALL cover overlap modes: with pattern "1011", drive "1011011" -> 2 matches with overlap=1; after cfg_overlap=0, the same stream gives 1 match.
REQ-029 SHALL cover reconfiguration: cfg_we with len=6 and pattern "110011" -> armed=0 and history cleared; "0110011" gives one match on the 7th bit; bits with bit_valid=0 inserted mid-stream do not change the result.
REQ-030 SHALL cover illegal config: cfg_we with cfg_len=1 while a bit is valid -> cfg_err pulse, configuration unchanged, bit discarded.
REQ-031 SHALL cover saturation with CNT_W=2: 5 matches -> match_count=3 and overflow=1; clr in the same cycle as a match -> match pulse emitted, match_count=0, overflow=0.
REQ-032 SHALL cover reset mid-stream: assert rst_n low after bits 1,0,1, release, then drive 1 -> no match.
